// File: rtl/hier_include_c_merge.sv
// ---------------------------------------------------------------------------
// hier_include_c_merge
//
// Purpose:
//   N-channel merge stage for cSizeT-style payloads. A round-robin arbiter
//   selects one of NUM_CH valid/ready input channels per cycle and writes the
//   payload, tagged with its source channel, into a small output FIFO that
//   feeds a single downstream consumer.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    per-channel valid
//   in_data     channel i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready    per-channel ready, at most one bit set (the arbiter winner)
//   out_valid   FIFO head valid
//   out_data    FIFO head payload
//   out_tag     FIFO head source channel
//   out_ready   downstream ready
//   fifo_count  current FIFO occupancy
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid and data stable until accepted; ready may
// depend combinationally on valid (and on out_ready), never the reverse.
// ---------------------------------------------------------------------------
module hier_include_c_merge #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int TAG_WIDTH = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [TAG_WIDTH-1:0]         out_tag,
  input  logic                         out_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // One extra bit so rr_ptr + offset can exceed NUM_CH-1 before wrapping.
  localparam int IW = TAG_WIDTH + 1;
  localparam int EW = DATA_WIDTH + TAG_WIDTH;

  // State
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [TAG_WIDTH-1:0] rr_q, rr_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];

  // Arbiter / datapath
  logic                  any_valid;
  logic [TAG_WIDTH-1:0]  winner;
  logic [IW-1:0]         cand;
  logic [IW-1:0]         winner_inc;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  pop;
  logic                  can_push;
  logic                  push;

  // -------------------------------------------------------------------------
  // Round-robin search: first valid channel starting at rr_q, wrapping at
  // NUM_CH (which need not be a power of two).
  // -------------------------------------------------------------------------
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, rr_q} + IW'(k);
      if (cand >= IW'(NUM_CH)) begin
        cand = cand - IW'(NUM_CH);
      end
      if (!any_valid && in_valid[cand[TAG_WIDTH-1:0]]) begin
        any_valid = 1'b1;
        winner    = cand[TAG_WIDTH-1:0];
      end
    end
  end

  // Payload of the winning channel.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (TAG_WIDTH'(k) == winner) begin
        win_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Handshake. A full FIFO still accepts a word when the head leaves in the
  // same cycle. Ready is forced low while reset is asserted.
  // -------------------------------------------------------------------------
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign can_push  = (count_q < CW'(FIFO_DEPTH)) | pop;
  assign push      = any_valid & can_push & rst_n;
  assign in_ready  = push ? (NUM_CH'(1) << winner) : '0;

  // -------------------------------------------------------------------------
  // Next state. rr_q only moves on a push, so a stalled winner keeps priority.
  // -------------------------------------------------------------------------
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rr_d       = rr_q;
    winner_inc = {1'b0, winner} + IW'(1);

    if (push) begin
      wptr_d = wptr_q + AW'(1);
      rr_d   = (winner_inc == IW'(NUM_CH)) ? '0 : winner_inc[TAG_WIDTH-1:0];
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rr_q    <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rr_q    <= rr_d;
    end
  end

  // Storage needs no reset: contents are only observed while count_q != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {winner, win_data};
    end
  end

  assign out_data   = mem_q[rptr_q][DATA_WIDTH-1:0];
  assign out_tag    = mem_q[rptr_q][EW-1:DATA_WIDTH];
  assign fifo_count = count_q;

  // -------------------------------------------------------------------------
  // Simulation-only invariants.
  // -------------------------------------------------------------------------
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(in_ready));
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CW'(FIFO_DEPTH));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> (count_q != '0));

endmodule

// File: tb/tb_hier_include_c_merge.sv
// ---------------------------------------------------------------------------
// tb_hier_include_c_merge
//
// Directed bench for hier_include_c_merge (4 channels, 8-bit payload, depth
// 4). Expected output words are queued as stimulus is driven; a monitor pops
// and compares on every output transfer.
// ---------------------------------------------------------------------------
module tb_hier_include_c_merge;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int FD = 4;
  localparam int TW = 2;
  localparam int EW = DW + TW;

  // ---------------------------------------------------------------- clock/reset
  logic           clk = 1'b0;
  logic           rst_n;
  logic [NC-1:0]  in_valid;
  logic [NC*DW-1:0] in_data;
  logic [NC-1:0]  in_ready;
  logic           out_valid;
  logic [DW-1:0]  out_data;
  logic [TW-1:0]  out_tag;
  logic           out_ready;
  logic [2:0]     fifo_count;

  always #5 clk = ~clk;

  hier_include_c_merge #(
    .DATA_WIDTH(DW),
    .NUM_CH    (NC),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_ready (out_ready),
    .fifo_count(fifo_count)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input int ch, input logic [DW-1:0] d);
    exp_q.push_back({TW'(ch), d});
  endtask

  // Output monitor: an output transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL out_unexpected: observed tag %0d data %0h expected no word",
               out_tag, out_data);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("out_word", 32'({out_tag, out_data}), 32'(mon_e));
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [DW-1:0] d);
    in_valid[ch]          = v;
    in_data[ch*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_empty(input int max_cycles);
    int n;
    n = 0;
    @(negedge clk);
    while (fifo_count !== 3'd0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk("drain_count", 32'(fifo_count), 0);
    chk("drain_out_valid", 32'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = '0;
    in_data   = '0;

    // Reset and idle; a valid input during reset must not see ready.
    #1 rst_n = 1'b0;
    set_ch(0, 1'b1, 8'h5A);
    #1;
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_held", 32'(in_ready), 0);
    tick();
    rst_n = 1'b1;
    set_ch(0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_out_valid", 32'(out_valid), 0);
      chk("idle_count", 32'(fifo_count), 0);
      chk("idle_in_ready", 32'(in_ready), 0);
    end

    // Single channel: ch2 streams 0x11, 0x22, 0x33.
    tick();
    for (int i = 0; i < 3; i++) begin
      set_ch(2, 1'b1, DW'(8'h11 * (i + 1)));
      @(negedge clk);
      chk("t2_in_ready", 32'(in_ready), 32'h4);
      chk("t2_count", 32'(fifo_count), (i == 0) ? 0 : 1);
      if (i == 0) chk("t2_no_bypass", 32'(out_valid), 0);
      expect_word(2, DW'(8'h11 * (i + 1)));
      tick();
    end
    set_ch(2, 1'b0, 8'h00);
    @(negedge clk);
    chk("t2_tail_count", 32'(fifo_count), 1);
    chk("t2_tail_valid", 32'(out_valid), 1);
    tick();
    @(negedge clk);
    chk("t2_empty", 32'(fifo_count), 0);

    // Round robin from channel 0 after a fresh reset.
    tick();
    do_reset();
    for (int c = 0; c < NC; c++) set_ch(c, 1'b1, DW'(8'hA0 + c));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_in_ready", 32'(in_ready), 32'(1) << (k % NC));
      expect_word(k % NC, DW'(8'hA0 + (k % NC)));
      tick();
    end
    in_valid = '0;
    @(negedge clk);
    chk("rr_tail_count", 32'(fifo_count), 1);
    tick();
    @(negedge clk);
    chk("rr_empty", 32'(fifo_count), 0);

    // Fill and backpressure on ch1.
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ch(1, 1'b1, DW'(8'h31 + i));
      @(negedge clk);
      chk("fill_in_ready", 32'(in_ready), 32'h2);
      chk("fill_count", 32'(fifo_count), i);
      expect_word(1, DW'(8'h31 + i));
      tick();
    end
    set_ch(1, 1'b1, 8'h35);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_count", 32'(fifo_count), 4);
      chk("full_in_ready", 32'(in_ready), 0);
      chk("full_head_data", 32'(out_data), 32'h31);
      chk("full_head_tag", 32'(out_tag), 1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_push_ready", 32'(in_ready), 32'h2);
    chk("full_pop_push_count", 32'(fifo_count), 4);
    expect_word(1, 8'h35);
    tick();
    set_ch(1, 1'b1, 8'h36);
    @(negedge clk);
    chk("full_pop_push_ready2", 32'(in_ready), 32'h2);
    chk("full_pop_push_count2", 32'(fifo_count), 4);
    expect_word(1, 8'h36);
    tick();
    set_ch(1, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_step_count", 32'(fifo_count), 4 - k);
      tick();
    end
    @(negedge clk);
    chk("fill_drained", 32'(fifo_count), 0);
    chk("fill_drained_valid", 32'(out_valid), 0);

    // Mid-stream reset with three words queued; rr pointer sits at 2.
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ch(1, 1'b1, DW'(8'h41 + i));
      @(negedge clk);
      chk("mr_in_ready", 32'(in_ready), 32'h2);
      expect_word(1, DW'(8'h41 + i));
      tick();
    end
    set_ch(1, 1'b0, 8'h00);
    @(negedge clk);
    chk("mr_count3", 32'(fifo_count), 3);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    set_ch(0, 1'b1, 8'h50);
    set_ch(3, 1'b1, 8'h53);
    #1;
    chk("mr_async_valid", 32'(out_valid), 0);
    chk("mr_async_count", 32'(fifo_count), 0);
    chk("mr_async_ready", 32'(in_ready), 0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mr_grant_ch0", 32'(in_ready), 32'h1);
    expect_word(0, 8'h50);
    tick();
    set_ch(0, 1'b0, 8'h00);
    @(negedge clk);
    chk("mr_grant_ch3", 32'(in_ready), 32'h8);
    expect_word(3, 8'h53);
    tick();
    set_ch(3, 1'b0, 8'h00);
    wait_empty(20);

    // Stalled winner: fill from ch0 (rr -> 1), then ch1 and ch2 wait.
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 1'b1, DW'(8'h71 + i));
      @(negedge clk);
      chk("sw_fill_ready", 32'(in_ready), 32'h1);
      chk("sw_fill_count", 32'(fifo_count), i);
      expect_word(0, DW'(8'h71 + i));
      tick();
    end
    set_ch(0, 1'b0, 8'h00);
    set_ch(1, 1'b1, 8'h61);
    @(negedge clk);
    chk("sw_full_ready", 32'(in_ready), 0);
    chk("sw_full_count", 32'(fifo_count), 4);
    tick();
    set_ch(2, 1'b1, 8'h62);
    @(negedge clk);
    chk("sw_full_ready2", 32'(in_ready), 0);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("sw_grant_ch1", 32'(in_ready), 32'h2);
    expect_word(1, 8'h61);
    tick();
    set_ch(1, 1'b0, 8'h00);
    @(negedge clk);
    chk("sw_grant_ch2", 32'(in_ready), 32'h4);
    expect_word(2, 8'h62);
    tick();
    set_ch(2, 1'b0, 8'h00);
    wait_empty(20);

    // ---------------------------------------------------------------- report
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
